// File: rtl/mna_pkg.sv
// Shared definitions for the master network adapter request path.
// Holds flit-type codes, the header read/write bit position, the
// packetizer FSM state encoding and a width helper.
package mna_pkg;

  // Flit type field, carried in the two MSBs of every flit.
  localparam logic [1:0] FlitHdr  = 2'b10;
  localparam logic [1:0] FlitBody = 2'b00;
  localparam logic [1:0] FlitTail = 2'b01;

  // Header payload bit flagging a read (1) or write (0) request.
  localparam int unsigned RdBitPos = 0;

  typedef enum logic [2:0] {
    StIdle,
    StWaitVc,
    StHdr,
    StBody,
    StTail
  } pkt_state_e;

  // clog2 that never returns less than 1, so a single-VC build still has an index bit.
  function automatic int unsigned clog2_min1(input int unsigned n);
    return (n <= 1) ? 1 : $clog2(n);
  endfunction

endpackage

// File: rtl/mna_vc_select.sv
// Lowest-index priority encoder over the free-VC vector.
// Ports:
//   vc_free_i   - bit i set when VC i can be allocated
//   vc_idx_o    - index of the lowest free VC (0 when none free)
//   vc_onehot_o - one-hot of the selected VC (all zero when none free)
//   any_free_o  - at least one VC is free
module mna_vc_select
  import mna_pkg::*;
#(
  parameter int unsigned NUM_VC = 8,
  parameter int unsigned VC_W   = clog2_min1(NUM_VC)
) (
  input  logic [NUM_VC-1:0] vc_free_i,
  output logic [VC_W-1:0]   vc_idx_o,
  output logic [NUM_VC-1:0] vc_onehot_o,
  output logic              any_free_o
);

  // Scan from the top down so the lowest set bit is the last one written.
  always_comb begin
    vc_idx_o    = '0;
    vc_onehot_o = '0;
    for (int i = NUM_VC - 1; i >= 0; i--) begin
      if (vc_free_i[i]) begin
        vc_idx_o       = VC_W'(i);
        vc_onehot_o    = '0;
        vc_onehot_o[i] = 1'b1;
      end
    end
  end

  assign any_free_o = |vc_free_i;

endmodule

// File: rtl/mna_req_packetizer.sv
// MNA request-flow packetizer. Accepts one AXI4-Lite style read or write
// request, claims the lowest free VC and serialises the request as
// HDR/[BODY]/TAIL flits on a valid/ready link.
// Ports:
//   clk, rst_n      - clock, asynchronous active-low reset
//   req_*           - request handshake and contents (write flag, addr, wdata)
//   vc_allocatable  - free-VC vector from the router
//   vc_claim        - one-hot VC held for the packet in flight
//   flit_*          - flit link toward the router
//   pkt_done        - one-cycle pulse on the tail handshake
module mna_req_packetizer
  import mna_pkg::*;
#(
  parameter int unsigned SRC_W    = 4,
  parameter logic [SRC_W-1:0] SRC_ADDR = 4'b0001,
  parameter int unsigned ADDR_W   = 32,
  parameter int unsigned DATA_W   = 32,
  parameter int unsigned NUM_VC   = 8,
  parameter int unsigned DEST_W   = 4,
  localparam int unsigned VC_W    = clog2_min1(NUM_VC),
  localparam int unsigned FLIT_W  = 2 + VC_W + DATA_W
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  input  logic [NUM_VC-1:0] vc_allocatable,
  output logic [NUM_VC-1:0] vc_claim,
  output logic              flit_valid,
  input  logic              flit_ready,
  output logic [FLIT_W-1:0] flit_data,
  output logic              pkt_done
);

  pkt_state_e        state_q, state_d;
  logic              write_q, write_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wdata_q, wdata_d;
  logic [VC_W-1:0]   vc_idx_q, vc_idx_d;
  logic [NUM_VC-1:0] vc_claim_q, vc_claim_d;

  logic [VC_W-1:0]   sel_idx;
  logic [NUM_VC-1:0] sel_onehot;
  logic              sel_any;

  logic [DATA_W-1:0] hdr_payload;
  logic [DATA_W-1:0] addr_ext;

  mna_vc_select #(
    .NUM_VC (NUM_VC),
    .VC_W   (VC_W)
  ) u_vc_select (
    .vc_free_i   (vc_allocatable),
    .vc_idx_o    (sel_idx),
    .vc_onehot_o (sel_onehot),
    .any_free_o  (sel_any)
  );

  always_comb begin
    state_d    = state_q;
    write_d    = write_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    vc_idx_d   = vc_idx_q;
    vc_claim_d = vc_claim_q;
    unique case (state_q)
      StIdle: begin
        if (req_valid) begin
          write_d = req_write;
          addr_d  = req_addr;
          wdata_d = req_wdata;
          state_d = StWaitVc;
        end
      end
      StWaitVc: begin
        // The VC is bound here once; vc_allocatable is ignored for the rest of the packet.
        if (sel_any) begin
          vc_idx_d   = sel_idx;
          vc_claim_d = sel_onehot;
          state_d    = StHdr;
        end
      end
      StHdr: begin
        if (flit_ready) state_d = write_q ? StBody : StTail;
      end
      StBody: begin
        if (flit_ready) state_d = StTail;
      end
      StTail: begin
        if (flit_ready) begin
          vc_idx_d   = '0;
          vc_claim_d = '0;
          state_d    = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      write_q    <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      vc_idx_q   <= '0;
      vc_claim_q <= '0;
    end else begin
      state_q    <= state_d;
      write_q    <= write_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      vc_idx_q   <= vc_idx_d;
      vc_claim_q <= vc_claim_d;
    end
  end

  // Header payload: DEST in the MSBs, source ID below it, read flag at bit 0.
  always_comb begin
    hdr_payload = '0;
    hdr_payload[DATA_W-1 -: DEST_W]          = addr_q[ADDR_W-1 -: DEST_W];
    hdr_payload[DATA_W-1-DEST_W -: SRC_W]    = SRC_ADDR;
    hdr_payload[RdBitPos]                    = ~write_q;
  end

  assign addr_ext = DATA_W'(addr_q);

  // Outputs come from latched request state only, so they hold under backpressure.
  always_comb begin
    flit_data  = '0;
    flit_valid = 1'b0;
    unique case (state_q)
      StHdr: begin
        flit_valid = 1'b1;
        flit_data  = {FlitHdr, vc_idx_q, hdr_payload};
      end
      StBody: begin
        flit_valid = 1'b1;
        flit_data  = {FlitBody, vc_idx_q, addr_ext};
      end
      StTail: begin
        flit_valid = 1'b1;
        flit_data  = {FlitTail, vc_idx_q, write_q ? wdata_q : addr_ext};
      end
      default: begin
        flit_valid = 1'b0;
        flit_data  = '0;
      end
    endcase
  end

  assign req_ready = (state_q == StIdle);
  assign vc_claim  = vc_claim_q;
  assign pkt_done  = (state_q == StTail) && flit_ready;

endmodule
